pipeline_accum: RTL and testbench

PIPELINE_ACCUM -- requirements
Module: pipeline_accum

---
 rtl/pipeline_accum_if.sv | 24 ++
 rtl/pipeline_accum.sv | 123 ++++++++++++
 tb/tb_pipeline_accum.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_accum_if.sv
// Stream bus for pipeline_accum: addend beats in, one registered frame result out.
interface pipeline_accum_if #(
    parameter int unsigned WIDTH     = 35,
    parameter int unsigned CNT_WIDTH = 8
) ();
    logic                 sclr;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_overflow;

    modport master (
        output sclr, in_valid, in_data, in_last,
        input  out_valid, out_sum, out_count, out_overflow
    );

    modport slave (
        input  sclr, in_valid, in_data, in_last,
        output out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/pipeline_accum.sv
// Frame accumulator with a two-segment carry-split adder: LS segment in stage 1,
// MS segment plus registered LS carry in stage 2, registered result in stage 3.
module pipeline_accum #(
    parameter int unsigned LS_WIDTH  = 15,
    parameter int unsigned MS_WIDTH  = 20,
    parameter int unsigned CNT_WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    pipeline_accum_if.slave bus
);
    localparam int unsigned WIDTH = LS_WIDTH + MS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Stage 1: LS running sum, per-beat flags, delayed MS addend
    logic                 r_open;
    logic                 r_v1, r_f1, r_l1, r_c1;
    logic [LS_WIDTH-1:0]  r_ls;
    logic [MS_WIDTH-1:0]  r_ms_d1;
    logic [CNT_WIDTH-1:0] r_cnt1;
    // Stage 2: MS running sum and sticky overflow
    logic                 r_v2, r_l2, r_ovf2;
    logic [LS_WIDTH-1:0]  r_ls2;
    logic [MS_WIDTH-1:0]  r_ms;
    logic [CNT_WIDTH-1:0] r_cnt2;
    // Stage 3: held frame result
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_sum;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic                 r_out_ovf;

    logic                 w_first;
    logic [LS_WIDTH-1:0]  w_ls_base, w_ls_sum;
    logic                 w_ls_cout;
    logic [MS_WIDTH-1:0]  w_ms_base, w_ms_sum;
    logic                 w_ms_cout;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_ovf_next;
    logic                 w_emit;

    // A first beat adds to zero, which loads the segment and forces its carry to 0
    assign w_first   = ~r_open;
    assign w_ls_base = w_first ? '0 : r_ls;
    assign {w_ls_cout, w_ls_sum} = {1'b0, w_ls_base} + {1'b0, bus.in_data[LS_WIDTH-1:0]};
    assign w_ms_base = r_f1 ? '0 : r_ms;
    assign {w_ms_cout, w_ms_sum} = {1'b0, w_ms_base} + {1'b0, r_ms_d1} + {{MS_WIDTH{1'b0}}, r_c1};
    assign w_cnt_next = w_first ? CNT_ONE : ((r_cnt1 == CNT_MAX) ? CNT_MAX : r_cnt1 + CNT_ONE);
    assign w_ovf_next = r_f1 ? w_ms_cout : (r_ovf2 | w_ms_cout);
    assign w_emit     = r_v2 & r_l2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open  <= 1'b0;
            r_v1    <= 1'b0;
            r_f1    <= 1'b0;
            r_l1    <= 1'b0;
            r_c1    <= 1'b0;
            r_ls    <= '0;
            r_ms_d1 <= '0;
            r_cnt1  <= '0;
        end else if (bus.sclr) begin
            r_open <= 1'b0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_open  <= ~bus.in_last;
                r_f1    <= w_first;
                r_l1    <= bus.in_last;
                r_c1    <= w_ls_cout;
                r_ls    <= w_ls_sum;
                r_ms_d1 <= bus.in_data[WIDTH-1:LS_WIDTH];
                r_cnt1  <= w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
            r_ovf2 <= 1'b0;
            r_ls2  <= '0;
            r_ms   <= '0;
            r_cnt2 <= '0;
        end else if (bus.sclr) begin
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_l2   <= r_l1;
                r_ovf2 <= w_ovf_next;
                r_ls2  <= r_ls;
                r_ms   <= w_ms_sum;
                r_cnt2 <= r_cnt1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (bus.sclr) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_sum   <= {r_ms, r_ls2};
                r_out_count <= r_cnt2;
                r_out_ovf   <= r_ovf2;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_out_sum;
    assign bus.out_count    = r_out_count;
    assign bus.out_overflow = r_out_ovf;
endmodule

// File: tb/tb_pipeline_accum.sv
// Directed vector table plus hand sequences for back-to-back, sclr, reset and saturation.
module tb_pipeline_accum;
    localparam int LS = 15;
    localparam int MS = 20;
    localparam int CW = 8;
    localparam int W  = LS + MS;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_accum_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    pipeline_accum #(.LS_WIDTH(LS), .MS_WIDTH(MS), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0]  sum;
        logic [CW-1:0] cnt;
        logic          ovf;
        int            at_edge;
    } res_t;

    typedef struct {
        int           n;
        logic [W-1:0] d [4];
        int           gap;
        logic [W-1:0] sum;
        int           cnt;
        logic         ovf;
    } vec_t;

    res_t q[$];
    vec_t tbl[NV];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk)
        if (!rst && bus.out_valid)
            q.push_back('{bus.out_sum, bus.out_count, bus.out_overflow, edge_cnt});

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Drives one cycle; t_res is the edge count at which a result from this beat is visible.
    task automatic beat(input logic v, input logic l, input logic [W-1:0] d, input logic s,
                        output int t_res);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        bus.sclr     = s;
        t_res = edge_cnt + 3;
    endtask

    task automatic idle(input int n);
        int t;
        repeat (n) beat(1'b0, 1'b0, '0, 1'b0, t);
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] sum, input int cnt,
                              input logic ovf, input int t_exp);
        int   waited = 0;
        int   t;
        res_t r;
        while (q.size() == 0 && waited < 20) begin
            beat(1'b0, 1'b0, '0, 1'b0, t);
            #1;
            waited++;
        end
        if (q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: no out_valid within 20 cycles, expected one", name);
            return;
        end
        r = q.pop_front();
        check({name, "_sum"},   64'(r.sum), 64'(sum));
        check({name, "_count"}, 64'(r.cnt), 64'(cnt));
        check({name, "_ovf"},   64'(r.ovf), 64'(ovf));
        check({name, "_edge"},  64'(r.at_edge), 64'(t_exp));
    endtask

    task automatic expect_none(input string name, input int n);
        idle(n);
        #1;
        check({name, "_no_pulse"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic set_vec(input int i, input int n, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3, input int gap,
                           input logic [W-1:0] sum, input int cnt, input logic ovf);
        tbl[i].n    = n;
        tbl[i].d[0] = d0;
        tbl[i].d[1] = d1;
        tbl[i].d[2] = d2;
        tbl[i].d[3] = d3;
        tbl[i].gap  = gap;
        tbl[i].sum  = sum;
        tbl[i].cnt  = cnt;
        tbl[i].ovf  = ovf;
    endtask

    initial begin
        int t, t1, t2, t3;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        bus.sclr     = 1'b0;

        set_vec(0, 2, 35'h7FFF, 35'h1, '0, '0, 0, 35'h8000, 2, 1'b0);
        set_vec(1, 3, 35'd10, 35'd20, 35'd30, '0, 3, 35'd60, 3, 1'b0);
        set_vec(2, 2, 35'h7_FFFF_FFFF, 35'h1, '0, '0, 0, 35'h0, 2, 1'b1);
        set_vec(3, 1, 35'd5, '0, '0, '0, 0, 35'd5, 1, 1'b0);
        set_vec(4, 2, 35'h7_FFF8_0000, 35'h0_0008_0000, '0, '0, 1, 35'h0, 2, 1'b1);
        set_vec(5, 3, 35'h4_0000_0000, 35'h3_FFFF_FFFF, 35'h1, '0, 0, 35'h0, 3, 1'b1);
        set_vec(6, 4, 35'h12345, 35'h54321, 35'h0ABCD, 35'h11111, 2, 35'h82344, 4, 1'b0);
        set_vec(7, 3, 35'h1_FFFF_FFFF, 35'h1_FFFF_FFFF, 35'h1_FFFF_FFFF, '0, 0, 35'h5_FFFF_FFFD, 3, 1'b0);

        repeat (3) @(negedge clk);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum",   64'(bus.out_sum), 64'd0);
        check("reset_count", 64'(bus.out_count), 64'd0);
        check("reset_ovf",   64'(bus.out_overflow), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            for (int b = 0; b < tbl[i].n; b++) begin
                beat(1'b1, b == tbl[i].n - 1, tbl[i].d[b], 1'b0, t);
                if (b == 0 && tbl[i].gap > 0) idle(tbl[i].gap);
            end
            expect_res($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].ovf, t);
            expect_none($sformatf("vec%0d", i), 4);
        end

        beat(1'b1, 1'b1, 35'd5, 1'b0, t1);
        beat(1'b1, 1'b1, 35'd7, 1'b0, t2);
        beat(1'b1, 1'b1, 35'd9, 1'b0, t3);
        expect_res("b2b0", 35'd5, 1, 1'b0, t1);
        expect_res("b2b1", 35'd7, 1, 1'b0, t2);
        expect_res("b2b2", 35'd9, 1, 1'b0, t3);
        expect_none("b2b", 4);

        // sclr mid-frame; the valid beat coinciding with sclr is ignored too
        beat(1'b1, 1'b0, 35'd1, 1'b0, t);
        beat(1'b1, 1'b0, 35'd2, 1'b0, t);
        beat(1'b1, 1'b1, 35'd100, 1'b1, t);
        beat(1'b1, 1'b1, 35'd4, 1'b0, t);
        expect_res("sclr_mid", 35'd4, 1, 1'b0, t);
        expect_none("sclr_mid", 4);

        beat(1'b1, 1'b1, 35'd8, 1'b0, t);
        beat(1'b0, 1'b0, '0, 1'b1, t);
        expect_none("sclr_after1", 5);
        beat(1'b1, 1'b1, 35'd8, 1'b0, t);
        beat(1'b0, 1'b0, '0, 1'b0, t);
        beat(1'b0, 1'b0, '0, 1'b1, t);
        expect_none("sclr_after2", 5);
        check("sclr_hold_sum", 64'(bus.out_sum), 64'd4);

        beat(1'b1, 1'b1, 35'd3, 1'b0, t);
        expect_res("post_sclr", 35'd3, 1, 1'b0, t);

        // Asynchronous reset mid-frame while a nonzero result is held
        beat(1'b1, 1'b0, 35'd1, 1'b0, t);
        beat(1'b1, 1'b0, 35'd2, 1'b0, t);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_sum",   64'(bus.out_sum), 64'd0);
        check("rst_async_count", 64'(bus.out_count), 64'd0);
        check("rst_async_ovf",   64'(bus.out_overflow), 64'd0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        beat(1'b1, 1'b1, 35'd4, 1'b0, t);
        expect_res("rst_mid", 35'd4, 1, 1'b0, t);
        expect_none("rst_mid", 4);

        // Long random frames against a wide reference sum; idle cycles carry junk with in_last=1
        for (int f = 0; f < 4; f++) begin
            int          n;
            logic [63:0] acc;
            logic [63:0] rr;
            n   = (f == 0) ? 300 : (f == 1) ? 255 : (f == 2) ? 256 : int'($urandom_range(1, 40));
            acc = '0;
            for (int b = 0; b < n; b++) begin
                rr = {$urandom(), $urandom()};
                acc += {29'd0, rr[W-1:0]};
                beat(1'b1, b == n - 1, rr[W-1:0], 1'b0, t);
                if (b != n - 1 && $urandom_range(0, 3) == 0) beat(1'b0, 1'b1, rr[W-1:0], 1'b0, t1);
            end
            expect_res($sformatf("rand%0d", f), acc[W-1:0], (n > 255) ? 255 : n,
                       acc[63:W] != '0, t);
            expect_none($sformatf("rand%0d", f), 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
